// File: rtl/fd_n_seq_if.sv
// Ratio-request and divider-drive bundle between the FMDLL loop control and the
// divide-by-N sequencer.
interface fd_n_seq_if #(
  parameter int unsigned W = 4
);
  logic         enable;
  logic [W-1:0] n_req;
  logic         n_req_valid;
  logic         n_req_ready;
  logic [W-1:0] N;
  logic [W-1:0] N_counter;
  logic         period_start;
  logic         settled;
  logic         err_illegal;

  modport master (
    output enable, n_req, n_req_valid,
    input  n_req_ready, N, N_counter, period_start, settled, err_illegal
  );

  modport slave (
    input  enable, n_req, n_req_valid,
    output n_req_ready, N, N_counter, period_start, settled, err_illegal
  );
endinterface

// File: rtl/fd_n_seq.sv
// Divide-by-N feedback divider sequencer: owns the phase counter and active ratio,
// applies ratio changes only at period boundaries and reports settling.
module fd_n_seq #(
  parameter int unsigned W              = 4,
  parameter int unsigned DEFAULT_N      = 4,
  parameter int unsigned SETTLE_PERIODS = 3
) (
  input  logic      clk_out,
  input  logic      rst_n,
  fd_n_seq_if.slave bus
);

  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    PEND   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    pend_q, pend_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            settled_q, settled_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            pstart_q, pstart_d;

  logic            accept;
  logic            legal;
  logic            boundary;
  logic [W-1:0]    cnt_step;

  // State and output registers
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= W'(DEFAULT_N);
      cnt_q     <= '0;
      pend_q    <= '0;
      settle_q  <= '0;
      settled_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      pstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      settle_q  <= settle_d;
      settled_q <= settled_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      pstart_q  <= pstart_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    err_d    = err_q;

    accept   = bus.n_req_valid && ready_q;
    legal    = (bus.n_req >= W'(2));
    boundary = (state_q != IDLE) && (cnt_q == n_q);
    cnt_step = boundary ? W'(1) : (cnt_q + W'(1));

    if (accept) begin
      err_d = !legal;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && legal) begin
          n_d = bus.n_req;
        end
        if (bus.enable) begin
          state_d  = SETTLE;
          cnt_d    = W'(1);
          settle_d = SW'(SETTLE_PERIODS);
        end
      end

      SETTLE: begin
        cnt_d = cnt_step;
        if (boundary) begin
          if (!bus.enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            settle_d = '0;
          end else begin
            settle_d = settle_q - SW'(1);
            if (settle_q == SW'(1)) begin
              state_d = RUN;
            end
          end
        end
      end

      RUN: begin
        cnt_d = cnt_step;
        if (boundary && !bus.enable) begin
          // Stopping: a request taken on this boundary still lands in N
          state_d = IDLE;
          cnt_d   = '0;
          if (accept && legal) begin
            n_d = bus.n_req;
          end
        end else if (accept && legal) begin
          state_d = PEND;
          pend_d  = bus.n_req;
        end
      end

      PEND: begin
        cnt_d = cnt_step;
        if (boundary) begin
          n_d = pend_q;
          if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d  = SETTLE;
            settle_d = SW'(SETTLE_PERIODS);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    settled_d = (state_d == RUN);
    ready_d   = (state_d == IDLE) || (state_d == RUN);
    pstart_d  = (state_d != IDLE) && (cnt_d == W'(1));
  end

  assign bus.N            = n_q;
  assign bus.N_counter    = cnt_q;
  assign bus.n_req_ready  = ready_q;
  assign bus.settled      = settled_q;
  assign bus.err_illegal  = err_q;
  assign bus.period_start = pstart_q;

endmodule

// File: tb/tb_fd_n_seq.sv
// Directed bench for fd_n_seq: flag-based period model checked every cycle,
// plus hand-computed literal checkpoints along the scripted scenario.
module tb_fd_n_seq;

  localparam int unsigned W  = 4;
  localparam int          DN = 4;
  localparam int          SP = 3;

  logic clk_out;
  logic rst_n;
  logic chk_on;

  int total;
  int bad;

  fd_n_seq_if #(.W(W)) bus ();

  fd_n_seq #(.W(W), .DEFAULT_N(DN), .SETTLE_PERIODS(SP)) dut (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  // Model: running flag, phase within period, ratio, optional pending ratio,
  // periods left before the ratio counts as settled.
  int m_run    = 0;
  int m_phase  = 0;
  int m_ratio  = DN;
  int m_pend   = -1;
  int m_settle = 0;
  int m_err    = 0;

  function automatic int m_settled_f(input int run, input int pend, input int stl);
    return (run != 0 && pend < 0 && stl == 0) ? 1 : 0;
  endfunction

  always @(posedge clk_out) begin
    int rdy, acc, leg, took, at_end, req;
    req = int'(bus.n_req);
    if (!rst_n) begin
      m_run = 0; m_phase = 0; m_ratio = DN; m_pend = -1; m_settle = 0; m_err = 0;
    end else begin
      rdy  = (m_run == 0 || m_settled_f(m_run, m_pend, m_settle) != 0) ? 1 : 0;
      acc  = (bus.n_req_valid && rdy != 0) ? 1 : 0;
      leg  = (req >= 2) ? 1 : 0;
      took = (acc != 0 && leg != 0) ? 1 : 0;
      if (acc != 0) m_err = (leg != 0) ? 0 : 1;
      if (m_run == 0) begin
        if (took != 0) m_ratio = req;
        if (bus.enable) begin
          m_run = 1; m_phase = 1; m_settle = SP;
        end
      end else begin
        at_end = (m_phase == m_ratio) ? 1 : 0;
        if (at_end == 0) begin
          m_phase = m_phase + 1;
          if (took != 0) m_pend = req;
        end else begin
          if (took != 0) m_pend = req;
          if (!bus.enable) begin
            if (m_pend >= 0) m_ratio = m_pend;
            m_pend = -1; m_run = 0; m_phase = 0; m_settle = 0;
          end else begin
            m_phase = 1;
            if (m_pend >= 0 && took == 0) begin
              m_ratio = m_pend; m_pend = -1; m_settle = SP;
            end else if (m_settle > 0) begin
              m_settle = m_settle - 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk_out) begin
    if (chk_on) begin
      chk("m_N",       int'(bus.N),            m_ratio);
      chk("m_cnt",     int'(bus.N_counter),    m_phase);
      chk("m_settled", int'(bus.settled),      m_settled_f(m_run, m_pend, m_settle));
      chk("m_ready",   int'(bus.n_req_ready),
          (m_run == 0 || m_settled_f(m_run, m_pend, m_settle) != 0) ? 1 : 0);
      chk("m_pstart",  int'(bus.period_start), (m_run != 0 && m_phase == 1) ? 1 : 0);
      chk("m_err",     int'(bus.err_illegal),  m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_out);
  endtask

  task automatic req(input int v);
    bus.n_req       = W'(v);
    bus.n_req_valid = 1'b1;
    tick(1);
    bus.n_req_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    chk_on = 1'b0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.n_req = '0;
    bus.n_req_valid = 1'b0;
    tick(2);
    chk_on = 1'b1;
    chk("rst_N", int'(bus.N), 4);
    chk("rst_cnt", int'(bus.N_counter), 0);
    chk("rst_ready", int'(bus.n_req_ready), 1);
    chk("rst_settled", int'(bus.settled), 0);
    rst_n = 1'b1;
    tick(1);

    // Start-up: 1,2,3,4 repeating, settled after the third count-4 cycle
    bus.enable = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      chk("start_cnt", int'(bus.N_counter), ((i - 1) % 4) + 1);
      if (i == 12) chk("start_settled12", int'(bus.settled), 0);
      if (i == 13) chk("start_settled13", int'(bus.settled), 1);
    end

    // Request 6 on a boundary: one more period of 4 first
    tick(3);
    chk("bnd_cnt4", int'(bus.N_counter), 4);
    req(6);
    chk("bnd_cnt1", int'(bus.N_counter), 1);
    chk("bnd_N_old", int'(bus.N), 4);
    chk("bnd_ready", int'(bus.n_req_ready), 0);
    tick(3);
    chk("bnd_cnt4b", int'(bus.N_counter), 4);
    tick(1);
    chk("bnd_N_new", int'(bus.N), 6);
    chk("bnd_pstart", int'(bus.period_start), 1);
    tick(17);
    chk("bnd_unsettled", int'(bus.settled), 0);
    chk("bnd_cnt6", int'(bus.N_counter), 6);
    tick(1);
    chk("bnd_settled", int'(bus.settled), 1);

    // Request 4 mid-period at count 2
    tick(1);
    req(4);
    chk("mid_cnt3", int'(bus.N_counter), 3);
    chk("mid_settled", int'(bus.settled), 0);
    tick(3);
    chk("mid_cnt6", int'(bus.N_counter), 6);
    chk("mid_N_old", int'(bus.N), 6);
    tick(1);
    chk("mid_N_new", int'(bus.N), 4);
    tick(11);
    chk("mid_unsettled", int'(bus.settled), 0);
    tick(1);
    chk("mid_settled2", int'(bus.settled), 1);

    // Illegal requests in RUN, then a legal 5
    req(1);
    chk("ill1_err", int'(bus.err_illegal), 1);
    chk("ill1_N", int'(bus.N), 4);
    chk("ill1_settled", int'(bus.settled), 1);
    req(0);
    chk("ill0_err", int'(bus.err_illegal), 1);
    chk("ill0_ready", int'(bus.n_req_ready), 1);
    req(5);
    chk("leg5_err", int'(bus.err_illegal), 0);
    chk("leg5_settled", int'(bus.settled), 0);
    tick(1);
    chk("leg5_N", int'(bus.N), 5);
    tick(14);
    chk("leg5_unsettled", int'(bus.settled), 0);
    tick(1);
    chk("leg5_settled", int'(bus.settled), 1);

    // Drop enable at count 2 with N=5, then re-enable
    tick(1);
    bus.enable = 1'b0;
    tick(3);
    chk("stop_cnt5", int'(bus.N_counter), 5);
    tick(1);
    chk("stop_cnt0", int'(bus.N_counter), 0);
    chk("stop_settled", int'(bus.settled), 0);
    tick(2);
    bus.enable = 1'b1;
    tick(1);
    chk("reen_cnt1", int'(bus.N_counter), 1);
    tick(14);
    chk("reen_unsettled", int'(bus.settled), 0);
    tick(1);
    chk("reen_settled", int'(bus.settled), 1);

    // Idle: illegal request, then legal request with enable in the same cycle
    bus.enable = 1'b0;
    tick(5);
    chk("idle_cnt0", int'(bus.N_counter), 0);
    req(0);
    chk("idle_err", int'(bus.err_illegal), 1);
    chk("idle_N", int'(bus.N), 5);
    bus.enable = 1'b1;
    req(3);
    chk("same_N", int'(bus.N), 3);
    chk("same_cnt", int'(bus.N_counter), 1);
    chk("same_err", int'(bus.err_illegal), 0);
    tick(3);
    chk("same_wrap", int'(bus.N_counter), 1);

    // Reset while a ratio of 9 is pending over N=4
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst2_N", int'(bus.N), 4);
    tick(13);
    chk("rst2_settled", int'(bus.settled), 1);
    req(9);
    chk("pend_ready", int'(bus.n_req_ready), 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("pendrst_N", int'(bus.N), 4);
    chk("pendrst_cnt", int'(bus.N_counter), 0);
    chk("pendrst_ready", int'(bus.n_req_ready), 1);
    bus.enable = 1'b0;
    tick(6);
    chk("pendrst_N_hold", int'(bus.N), 4);
    bus.enable = 1'b1;
    tick(5);
    chk("pendrst_run_N", int'(bus.N), 4);
    chk("pendrst_run_cnt", int'(bus.N_counter), 1);
    tick(3);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fd_n_seq.md
Name: fd_n_seq

Overview:
- Sequencer for the divide-by-N feedback divider in the FMDLL loop.
- Owns the divider phase counter (N_counter) and the active division ratio (N), both driven into the divider decode.
- Accepts ratio-change requests through a valid/ready handshake and applies them only at a period boundary, so the divider never sees a counter value above N.
- Holds a "settled" flag low for a programmable number of periods after start-up or after a ratio change, for downstream lock logic.

Parameters:
- W, 4, width of N and N_counter.
- DEFAULT_N, 4, ratio loaded at reset; legal range 2..2^W-1.
- SETTLE_PERIODS, 3, complete divider periods after a start or ratio change before settled asserts; legal range 1..15.

Ports:
- clk_out  input  1  DLL output clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk_out.
- enable  input  1  run request for the divider.
- n_req  input  W  requested division ratio.
- n_req_valid  input  1  n_req is valid.
- n_req_ready  output  1  request accepted on valid&ready at posedge.
- N  output  W  active ratio to the divider, registered.
- N_counter  output  W  divider phase count, registered; 0 when idle, 1..N when running.
- period_start  output  1  high in every cycle where running and N_counter==1.
- settled  output  1  ratio stable for SETTLE_PERIODS periods, registered.
- err_illegal  output  1  sticky; last accepted request was out of range.

Behaviour:
- Reset: rst_n low at a posedge sets the following, regardless of state or pending request:
  - state=IDLE, N=DEFAULT_N, N_counter=0, settle count=0.
  - settled=0, err_illegal=0, period_start=0, n_req_ready=1.
- Reset mid-PEND discards the pending ratio.
- States: IDLE, SETTLE, RUN, PEND.
- Counter, in SETTLE/RUN/PEND: a boundary cycle is one with N_counter==N.
  - In a boundary cycle, next N_counter=1; otherwise N_counter+1.
  - N_counter never exceeds N.
- n_req_ready=1 in IDLE and RUN; 0 in SETTLE and PEND.
- Request validity:
  - An accepted n_req is legal when 2 <= n_req <= 2^W-1.
  - An illegal request sets err_illegal=1 and changes nothing else; state is unchanged.
  - A legal accepted request clears err_illegal.
- IDLE:
  - N_counter=0.
  - A legal request loads N on the next cycle.
  - enable=1 moves to SETTLE with N_counter=1 and settle count=SETTLE_PERIODS.
  - A request and enable in the same cycle: the new N is used from the first period.
- SETTLE:
  - Each boundary cycle decrements the settle count.
  - At the boundary where the count reaches 0, the next state is RUN and settled=1 from the next cycle.
- RUN:
  - settled=1.
  - A legal accept sets the next state to PEND, stores the pending ratio and drives settled=0 on the next cycle.
- PEND:
  - The old N keeps counting.
  - At the first boundary cycle while in PEND: N takes the pending ratio, N_counter=1, settle count=SETTLE_PERIODS, next state SETTLE.
  - An accept that occurs in a RUN boundary cycle lets that boundary pass with the old N; the change applies at the following boundary.
- enable is sampled only in boundary cycles (SETTLE/RUN/PEND). If low at a boundary:
  - Next state is IDLE with N_counter=0 and settled=0.
  - Any pending ratio is applied to N.
- Re-enable from IDLE always passes through SETTLE.
- period_start is decoded from registered state, so it has zero added latency.
- All other outputs have 1-cycle latency from the triggering posedge.

Test Plan:
- Reset, enable=1, DEFAULT_N=4, SETTLE_PERIODS=3:
  - N_counter runs 0,1,2,3,4,1,2,3,4,...
  - settled rises on the cycle after the 3rd count-4 cycle (cycle 13 after enable).
- In RUN with N=4, request n_req=6 accepted at N_counter=2:
  - Counter completes 3,4, then runs 1..6 with N=6 from the N_counter=1 cycle.
  - settled=0 from the cycle after accept until 3 periods of 6 complete.
  - n_req_ready=0 throughout.
- Request accepted exactly at N_counter=4 (boundary): one further full period of 4 runs before N=6 applies.
- Illegal requests n_req=1 and n_req=0 in RUN:
  - err_illegal=1, N stays 4, state stays RUN, settled stays 1.
  - A subsequent legal n_req=5 clears err_illegal.
- Drop enable at N_counter=2 with N=5:
  - Counter finishes 3,4,5, then 0; settled=0.
  - Re-enable gives 1..5 and settled after 3 periods.
- Assert rst_n=0 for one cycle while in PEND (pending 9, N=4):
  - Next cycle N=DEFAULT_N=4, N_counter=0, IDLE, n_req_ready=1, pending 9 discarded.
